turfio_cout_sched: RTL and testbench
====================================

// Module: turfio_cout_sched
// PURPOSE
//  Arbitrates up to NREQ command-word sources onto the single SURF->TURFIO COUT
//  serial link and presents at most one 32-bit word per 8-ifclk COUT frame.
//  Keeps a frame-phase counter locked to ifclk_sync_i, matching the COUT serializer.
//  Output changes only on the serializer's capture edge. Sits between response
//  generators (register readback, status, trigger ack) and the COUT serializer.
// PARAMETERS
//  NREQ        4     number of requesters (1..8)
//  PRIO_REQ0   1'b0  1: requester 0 is strict priority; others round-robin. 0: all round-robin
// PORTS
//  ifclk_i        in   1        interface clock; all logic in this domain
//  rst_i          in   1        synchronous, active-high reset
//  ifclk_sync_i   in   1        frame sync pulse (same net the serializer uses)
//  train_i        in   1        link in training; no grants while high
//  req_data_i     in   NREQx32  per-requester command word
//  req_valid_i    in   NREQ     per-requester valid
//  req_ready_o    out  NREQ     per-requester ready; transfer = valid & ready
//  cout_data_o    out  32       word to serializer (cout_data_i)
//  cout_valid_o   out  1        word valid to serializer (cout_valid_i)
//  synced_o       out  1        phase counter has seen at least one sync
//  sync_err_o     out  1        sticky: sync arrived at unexpected phase
//  sent_count_o   out  16       words sent (wraps)
// BEHAVIOUR
//  - Reset values (all outputs): cout_data_o=0, cout_valid_o=0, req_ready_o=0,
//    synced_o=0, sync_err_o=0, sent_count_o=0, phase=0, rr pointer=0.
//  - sync_buf <= ifclk_sync_i (one register).
//  - Phase counter: if sync_buf then phase<=1 else phase<=phase+1 (3-bit wrap).
//  - First sync_buf sets synced_o (held until reset).
//  - Alignment check: sync_buf & synced_o & phase!=0 -> sync_err_o<=1 (sticky).
//    The counter still realigns to 1; no word is dropped or duplicated.
//  - Commit edge = rising edge with phase==7.
//  - req_ready_o is combinational: one-hot grant & {NREQ{phase==7 & synced_o & ~train_i}}.
//    It is all-zero in every other cycle.
//  - Grant (combinational, over req_valid_i):
//    - PRIO_REQ0 & valid[0] -> requester 0.
//    - Otherwise: first valid at or after rr pointer, searching upward with wrap.
//  - At commit edge with a grant:
//    - cout_data_o <= granted data; cout_valid_o <= 1; sent_count_o += 1.
//    - rr pointer <= granted index + 1 (mod NREQ). Strict-priority grants to req 0 do not move it.
//  - At commit edge, no grant (no valid, train_i, or !synced_o): cout_valid_o <= 0.
//    cout_data_o holds its value. Serializer then emits 0x80008000 idle.
//  - Outputs are stable for exactly 8 cycles (phase 0..7). Serializer samples
//    the pre-edge value at its own phase 7, so the word loaded at edge K is sent frame K+1.
//  - Requester contract: valid, once high, must not drop and data must not change until accepted.
//    Violations are not detected.
//  - Single-requester back-to-back: max one word per 8 cycles; no bubbles while valid stays high.
//  - train_i rising mid-frame: the current word still completes. Next commit is idle.
//  - rst_i mid-frame: immediate return to reset values. synced_o clears; waits for the next sync.
// STRUCTURE
//  - Shared package turfio_cout_pkg:
//    - COUT_FRAME_LEN=8, COMMAND_PHASE_RESET_VAL=3'd1, COUT_CAPTURE_PHASE=3'd7.
//    - COUT_IDLE_WORD=32'h80008000, COUT_TRAIN_WORD=32'hA55A6996.
//  - Serializer and this block both import the package.
//  - Sub-module rr_arbiter #(N): inputs req, ptr, prio_en; outputs onehot grant, idx.
//    Purely combinational.
// TESTING
//  1 No sync after reset, req0 valid=0x12345678 -> ready never asserts; cout_valid_o=0; synced_o=0.
//  2 Sync once, req1 valid=0xDEADBEEF -> ready[1] high only in phase-7 cycle;
//    next cycle cout_data_o=0xDEADBEEF, cout_valid_o=1 for 8 cycles; sent_count_o=1.
//  3 Reqs 0..3 all valid, PRIO_REQ0=0 -> grants 0,1,2,3,0 over consecutive frames.
//    Repeat with PRIO_REQ0=1: grants 0,0,0 while req0 stays valid.
//  4 train_i high with reqs valid -> no ready, cout_valid_o=0.
//    train_i drops -> first grant at the next phase-7.
//  5 Sync every 8 cycles -> sync_err_o stays 0. Then a sync 3 cycles early ->
//    sync_err_o=1, phase restarts at 1, and the next commit occurs 7 cycles later.
//  6 rst_i pulsed at phase 4 with cout_valid_o=1 -> all outputs return to reset
//    values on the next edge; no grant until a new sync.

Source files
------------

// File: rtl/turfio_cout_pkg.sv
// Shared constants and types for the SURF->TURFIO COUT link: frame geometry,
// capture phase and the fixed idle/training words the serializer emits.
package turfio_cout_pkg;

    localparam int unsigned COUT_FRAME_LEN = 8;
    localparam int unsigned PHASE_W        = $clog2(COUT_FRAME_LEN);
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned COUNT_W        = 16;

    localparam logic [PHASE_W-1:0] COMMAND_PHASE_RESET_VAL = 3'd1;
    localparam logic [PHASE_W-1:0] COUT_CAPTURE_PHASE      = 3'd7;

    typedef logic [WORD_W-1:0] cout_word_t;

    localparam cout_word_t COUT_IDLE_WORD  = 32'h8000_8000;
    localparam cout_word_t COUT_TRAIN_WORD = 32'hA55A_6996;

    // Index width for an N-entry one-hot, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/turfio_cout_sched_if.sv
// Requester-side and serializer-side signals of the COUT scheduler.
// master = requesters/serializer/sync source, slave = scheduler.
interface turfio_cout_sched_if #(
    parameter int unsigned NREQ = 4
);
    import turfio_cout_pkg::*;

    logic                          ifclk_sync_i;
    logic                          train_i;
    logic [NREQ-1:0][WORD_W-1:0]   req_data_i;
    logic [NREQ-1:0]               req_valid_i;
    logic [NREQ-1:0]               req_ready_o;
    cout_word_t                    cout_data_o;
    logic                          cout_valid_o;
    logic                          synced_o;
    logic                          sync_err_o;
    logic [COUNT_W-1:0]            sent_count_o;

    modport master (
        output ifclk_sync_i, train_i, req_data_i, req_valid_i,
        input  req_ready_o, cout_data_o, cout_valid_o, synced_o, sync_err_o, sent_count_o
    );

    modport slave (
        input  ifclk_sync_i, train_i, req_data_i, req_valid_i,
        output req_ready_o, cout_data_o, cout_valid_o, synced_o, sync_err_o, sent_count_o
    );

endinterface

// File: rtl/turfio_cout_sched_rr_arbiter.sv
// Combinational round-robin arbiter with optional strict priority for request 0.
// Searches upward from ptr with wrap; returns one-hot grant and its index.
module rr_arbiter
    import turfio_cout_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          prio_en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        if (prio_en && req[0]) begin
            grant[0] = 1'b1;
            any      = 1'b1;
        end
        for (int unsigned i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (IW+1)'(i);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!any && req[IW'(pos)]) begin
                grant[IW'(pos)] = 1'b1;
                idx             = IW'(pos);
                any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/turfio_cout_sched.sv
// Schedules requester command words onto the COUT link, one word per 8-cycle
// frame, committed on the serializer's phase-7 capture edge.
module turfio_cout_sched
    import turfio_cout_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter logic        PRIO_REQ0 = 1'b0
) (
    input  logic                  ifclk_i,
    input  logic                  rst_i,
    turfio_cout_sched_if.slave    bus
);

    localparam int unsigned IDX_W = idx_w(NREQ);

    logic               sync_buf;
    logic [PHASE_W-1:0] phase;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NREQ-1:0]    grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               commit_c;
    logic               grant_ok_c;
    logic [IDX_W-1:0]   ptr_next_c;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req     (bus.req_valid_i),
        .ptr     (rr_ptr),
        .prio_en (PRIO_REQ0),
        .grant   (grant),
        .idx     (grant_idx),
        .any     (grant_any)
    );

    assign commit_c        = (phase == COUT_CAPTURE_PHASE);
    assign grant_ok_c      = commit_c & bus.synced_o & ~bus.train_i;
    assign bus.req_ready_o = grant & {NREQ{grant_ok_c}};
    assign ptr_next_c      = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);

    // Phase tracking, alignment check and word commit.
    always_ff @(posedge ifclk_i) begin
        if (rst_i) begin
            sync_buf         <= 1'b0;
            phase            <= '0;
            rr_ptr           <= '0;
            bus.cout_data_o  <= '0;
            bus.cout_valid_o <= 1'b0;
            bus.synced_o     <= 1'b0;
            bus.sync_err_o   <= 1'b0;
            bus.sent_count_o <= '0;
        end else begin
            sync_buf <= bus.ifclk_sync_i;
            phase    <= sync_buf ? COMMAND_PHASE_RESET_VAL : phase + PHASE_W'(1);
            if (sync_buf) begin
                bus.synced_o <= 1'b1;
            end
            // A sync landing anywhere but the frame boundary means we lost lock.
            if (sync_buf && bus.synced_o && (phase != '0)) begin
                bus.sync_err_o <= 1'b1;
            end
            if (commit_c) begin
                if (grant_ok_c && grant_any) begin
                    bus.cout_data_o  <= bus.req_data_i[grant_idx];
                    bus.cout_valid_o <= 1'b1;
                    bus.sent_count_o <= bus.sent_count_o + COUNT_W'(1);
                    if (!(PRIO_REQ0 && (grant_idx == '0))) begin
                        rr_ptr <= ptr_next_c;
                    end
                end else begin
                    bus.cout_valid_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_turfio_cout_sched.sv
// Directed bench for turfio_cout_sched: one round-robin instance and one with
// strict priority on requester 0, sharing clock, reset, sync and train.
module tb_turfio_cout_sched;

    logic clk;
    logic rst;
    logic sync;
    logic train;

    int ntests = 0;
    int nfail  = 0;
    int ph     = 0;
    logic sb   = 1'b0;

    logic [3:0][31:0] dat;
    int ord_a [5] = '{0, 1, 2, 3, 0};
    logic [31:0] oh;

    turfio_cout_sched_if #(.NREQ(4)) ifa ();
    turfio_cout_sched_if #(.NREQ(4)) ifb ();

    assign ifa.ifclk_sync_i = sync;
    assign ifb.ifclk_sync_i = sync;
    assign ifa.train_i      = train;
    assign ifb.train_i      = train;

    turfio_cout_sched #(.NREQ(4), .PRIO_REQ0(1'b0)) dut_a (
        .ifclk_i (clk),
        .rst_i   (rst),
        .bus     (ifa)
    );

    turfio_cout_sched #(.NREQ(4), .PRIO_REQ0(1'b1)) dut_b (
        .ifclk_i (clk),
        .rst_i   (rst),
        .bus     (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and update the bench's own frame-phase model.
    task automatic cyc();
        logic s;
        logic r;
        s = sync;
        r = rst;
        @(posedge clk);
        #2;
        if (r) begin
            ph = 0;
            sb = 1'b0;
        end else begin
            ph = sb ? 1 : (ph + 1) % 8;
            sb = s;
        end
    endtask

    task automatic go_p7();
        for (int k = 0; k < 8 && ph != 7; k++) cyc();
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_data"},  ifa.cout_data_o, 32'h0);
        chk({pfx, "_valid"}, 32'(ifa.cout_valid_o), 32'h0);
        chk({pfx, "_ready"}, 32'(ifa.req_ready_o), 32'h0);
        chk({pfx, "_synced"}, 32'(ifa.synced_o), 32'h0);
        chk({pfx, "_err"},   32'(ifa.sync_err_o), 32'h0);
        chk({pfx, "_count"}, 32'(ifa.sent_count_o), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        sync  = 1'b0;
        train = 1'b0;
        for (int i = 0; i < 4; i++) dat[i] = 32'hA000_0000 | 32'(i);
        ifa.req_valid_i = '0;
        ifa.req_data_i  = '0;
        ifb.req_valid_i = '0;
        ifb.req_data_i  = '0;
        cyc();
        cyc();
        rst = 1'b0;
        chk_reset("reset");

        // No sync ever seen: requester stays unserved.
        ifa.req_data_i[0] = 32'h1234_5678;
        ifa.req_valid_i   = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("t1_ready", 32'(ifa.req_ready_o), 32'h0);
        end
        chk("t1_valid",  32'(ifa.cout_valid_o), 32'h0);
        chk("t1_synced", 32'(ifa.synced_o), 32'h0);
        chk("t1_count",  32'(ifa.sent_count_o), 32'h0);
        ifa.req_valid_i = '0;

        // Single sync, single requester.
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        cyc();
        chk("t2_synced", 32'(ifa.synced_o), 32'h1);
        ifa.req_data_i[1] = 32'hDEAD_BEEF;
        ifa.req_valid_i   = 4'b0010;
        #1;
        chk("t2_ready_p1", 32'(ifa.req_ready_o), 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_ready_early", 32'(ifa.req_ready_o), 32'h0);
        end
        cyc();
        chk("t2_ready_p7", 32'(ifa.req_ready_o), 32'h2);
        cyc();
        ifa.req_valid_i = '0;
        chk("t2_data",  ifa.cout_data_o, 32'hDEAD_BEEF);
        chk("t2_valid", 32'(ifa.cout_valid_o), 32'h1);
        chk("t2_count", 32'(ifa.sent_count_o), 32'h1);
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("t2_hold_valid", 32'(ifa.cout_valid_o), 32'h1);
            chk("t2_hold_data",  ifa.cout_data_o, 32'hDEAD_BEEF);
        end
        chk("t2_ready_idle", 32'(ifa.req_ready_o), 32'h0);
        cyc();
        chk("t2_idle_valid", 32'(ifa.cout_valid_o), 32'h0);
        chk("t2_idle_data",  ifa.cout_data_o, 32'hDEAD_BEEF);

        // All four valid: round-robin on A, strict priority on B.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t3_rst_synced", 32'(ifa.synced_o), 32'h0);
        ifa.req_data_i  = dat;
        ifb.req_data_i  = dat;
        ifa.req_valid_i = 4'b1111;
        ifb.req_valid_i = 4'b1111;
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            go_p7();
            oh = 32'd1 << ord_a[k];
            chk($sformatf("t3_a_ready%0d", k), 32'(ifa.req_ready_o), oh);
            chk($sformatf("t3_b_ready%0d", k), 32'(ifb.req_ready_o), 32'h1);
            cyc();
            chk($sformatf("t3_a_data%0d", k), ifa.cout_data_o, dat[ord_a[k]]);
            chk($sformatf("t3_b_data%0d", k), ifb.cout_data_o, dat[0]);
            chk($sformatf("t3_a_count%0d", k), 32'(ifa.sent_count_o), 32'(k + 1));
            chk($sformatf("t3_b_count%0d", k), 32'(ifb.sent_count_o), 32'(k + 1));
        end
        ifb.req_valid_i = '0;

        // Training raised mid-frame: current word completes, then idle.
        cyc();
        cyc();
        cyc();
        train = 1'b1;
        go_p7();
        chk("t4_ready_train", 32'(ifa.req_ready_o), 32'h0);
        chk("t4_valid_hold",  32'(ifa.cout_valid_o), 32'h1);
        chk("t4_data_hold",   ifa.cout_data_o, dat[0]);
        cyc();
        chk("t4_valid_idle", 32'(ifa.cout_valid_o), 32'h0);
        chk("t4_data_idle",  ifa.cout_data_o, dat[0]);
        go_p7();
        chk("t4_ready_train2", 32'(ifa.req_ready_o), 32'h0);
        cyc();
        chk("t4_valid_idle2", 32'(ifa.cout_valid_o), 32'h0);
        chk("t4_count_train", 32'(ifa.sent_count_o), 32'd5);
        train = 1'b0;
        go_p7();
        chk("t4_ready_resume", 32'(ifa.req_ready_o), 32'h2);
        cyc();
        chk("t4_data_resume",  ifa.cout_data_o, dat[1]);
        chk("t4_valid_resume", 32'(ifa.cout_valid_o), 32'h1);
        chk("t4_count_resume", 32'(ifa.sent_count_o), 32'd6);
        ifa.req_valid_i = '0;

        // Aligned syncs, then one arriving three cycles early.
        for (int i = 0; i < 3; i++) begin
            go_p7();
            sync = 1'b1;
            cyc();
            sync = 1'b0;
            cyc();
            chk("t5_err_aligned", 32'(ifa.sync_err_o), 32'h0);
        end
        cyc();
        cyc();
        cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        ifa.req_data_i[2] = 32'hC0FF_EE02;
        ifa.req_valid_i   = 4'b0100;
        cyc();
        chk("t5_err_early", 32'(ifa.sync_err_o), 32'h1);
        chk("t5_ready_realign", 32'(ifa.req_ready_o), 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t5_ready_wait", 32'(ifa.req_ready_o), 32'h0);
        end
        cyc();
        chk("t5_ready_p7", 32'(ifa.req_ready_o), 32'h4);
        cyc();
        ifa.req_valid_i = '0;
        chk("t5_data",  ifa.cout_data_o, 32'hC0FF_EE02);
        chk("t5_valid", 32'(ifa.cout_valid_o), 32'h1);
        chk("t5_count", 32'(ifa.sent_count_o), 32'd7);
        chk("t5_err_sticky", 32'(ifa.sync_err_o), 32'h1);

        // Reset mid-frame while a word is on the link.
        cyc();
        cyc();
        cyc();
        cyc();
        chk("t6_valid_before", 32'(ifa.cout_valid_o), 32'h1);
        rst = 1'b1;
        cyc();
        chk_reset("t6_reset");
        rst = 1'b0;
        ifa.req_data_i[0] = 32'h1234_5678;
        ifa.req_valid_i   = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk("t6_ready_nosync", 32'(ifa.req_ready_o), 32'h0);
        end
        chk("t6_synced_nosync", 32'(ifa.synced_o), 32'h0);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        cyc();
        go_p7();
        chk("t6_ready_p7", 32'(ifa.req_ready_o), 32'h1);
        cyc();
        chk("t6_data",  ifa.cout_data_o, 32'h1234_5678);
        chk("t6_valid", 32'(ifa.cout_valid_o), 32'h1);
        chk("t6_count", 32'(ifa.sent_count_o), 32'h1);
        ifa.req_valid_i = '0;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
